// File: rtl/cpu_clock_scheduler.sv
// CPU advance sequencer: produces a one-cycle cpu_en pulse in RUN (divided rate),
// on a debounced button press in STEP, or never (HALT/BREAK), with a cycle breakpoint.
//
// state | meaning
// ------+----------------------------------------------------------
// HALT  | no pulses; waits for mode RUN or STEP
// RUN   | cpu_en every div_lat cycles; may fall into BREAK
// STEP  | one cpu_en per debounced button press
// BREAK | breakpoint hit; no pulses until mode returns to HALT
module cpu_clock_scheduler #(
    parameter int DEBOUNCE = 1000000,
    parameter int DIV_W    = 32
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic [1:0]       mode,
    input  logic             step_btn,
    input  logic [DIV_W-1:0] div_val,
    input  logic             bp_en,
    input  logic [DIV_W-1:0] bp_cycle,
    output logic             cpu_en,
    output logic             slow_clk,
    output logic [DIV_W-1:0] cycle_count,
    output logic [1:0]       state,
    output logic             halted
);

    localparam logic [1:0] S_HALT  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_STEP  = 2'd2;
    localparam logic [1:0] S_BREAK = 2'd3;

    localparam logic [1:0] M_RUN  = 2'b01;
    localparam logic [1:0] M_STEP = 2'b10;

    localparam int DB_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE - 1);

    logic            btn_meta;
    logic            btn_sync;
    logic            btn_stable;
    logic            btn_prev;
    logic [DB_W-1:0] db_cnt;
    logic            step_req;

    logic [1:0]       state_d;
    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_cnt_d;
    logic [DIV_W-1:0] div_lat;
    logic [DIV_W-1:0] div_lat_d;
    logic [DIV_W-1:0] count_inc;
    logic             mode_halt;
    logic             tick;
    logic             bp_hit;
    logic             pulse_d;

    // Button path: 2-flop synchronizer, then a stability counter.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            btn_meta   <= 1'b0;
            btn_sync   <= 1'b0;
            btn_stable <= 1'b0;
            btn_prev   <= 1'b0;
            db_cnt     <= '0;
        end else begin
            btn_meta <= step_btn;
            btn_sync <= btn_meta;
            btn_prev <= btn_stable;
            if (btn_sync != btn_stable) begin
                if (db_cnt == DB_LAST) begin
                    btn_stable <= btn_sync;
                    db_cnt     <= '0;
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

    assign step_req  = btn_stable & ~btn_prev;
    assign mode_halt = (mode != M_RUN) && (mode != M_STEP);
    assign count_inc = cycle_count + 1'b1;
    assign tick      = (state == S_RUN) && (mode == M_RUN) && (div_cnt == div_lat - 1'b1);
    assign bp_hit    = bp_en && (count_inc == bp_cycle);

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) state <= S_HALT;
        else        state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            S_HALT: begin
                if (mode == M_RUN)       state_d = S_RUN;
                else if (mode == M_STEP) state_d = S_STEP;
            end
            S_RUN: begin
                if (mode_halt)           state_d = S_HALT;
                else if (mode == M_STEP) state_d = S_STEP;
                else if (tick && bp_hit) state_d = S_BREAK;
            end
            S_STEP: begin
                if (mode_halt)           state_d = S_HALT;
                else if (mode == M_RUN)  state_d = S_RUN;
            end
            default: begin
                if (mode_halt)           state_d = S_HALT;
            end
        endcase
    end

    // Divider latch is loaded on every entry into RUN; a zero divisor acts as one.
    always_comb begin
        div_cnt_d = div_cnt;
        div_lat_d = div_lat;
        pulse_d   = tick || ((state == S_STEP) && (mode == M_STEP) && step_req);
        if (((state == S_HALT) || (state == S_STEP)) && (mode == M_RUN)) begin
            div_lat_d = (div_val == '0) ? DIV_W'(1) : div_val;
            div_cnt_d = '0;
        end else if (state == S_RUN) begin
            if (mode != M_RUN || tick) div_cnt_d = '0;
            else                       div_cnt_d = div_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            cpu_en      <= 1'b0;
            slow_clk    <= 1'b0;
            cycle_count <= '0;
            div_cnt     <= '0;
            div_lat     <= DIV_W'(1);
        end else begin
            cpu_en  <= pulse_d;
            div_cnt <= div_cnt_d;
            div_lat <= div_lat_d;
            if (pulse_d) begin
                slow_clk    <= ~slow_clk;
                cycle_count <= count_inc;
            end
        end
    end

    assign halted = (state == S_HALT) || (state == S_BREAK);

endmodule

// File: tb/tb_cpu_clock_scheduler.sv
// Self-checking bench for cpu_clock_scheduler (DEBOUNCE=4, DIV_W=4 so wrap is reachable).
module tb_cpu_clock_scheduler;

    logic       clk_in = 1'b0;
    logic       rst_n  = 1'b0;
    logic [1:0] mode   = 2'b00;
    logic       step_btn = 1'b0;
    logic [3:0] div_val  = 4'd0;
    logic       bp_en    = 1'b0;
    logic [3:0] bp_cycle = 4'd0;
    logic       cpu_en;
    logic       slow_clk;
    logic [3:0] cycle_count;
    logic [1:0] state;
    logic       halted;

    int total = 0;
    int bad   = 0;
    logic [3:0] exp_count;
    logic       exp_slow;

    cpu_clock_scheduler #(.DEBOUNCE(4), .DIV_W(4)) dut (
        .clk_in(clk_in), .rst_n(rst_n), .mode(mode), .step_btn(step_btn),
        .div_val(div_val), .bp_en(bp_en), .bp_cycle(bp_cycle),
        .cpu_en(cpu_en), .slow_clk(slow_clk), .cycle_count(cycle_count),
        .state(state), .halted(halted)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        mode = 2'b00;
        exp_count = 4'd0;
        exp_slow  = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        tick();
        total++; if (cpu_en !== 1'b0)      begin bad++; $display("FAIL reset_cpu_en got=%0b want=0", cpu_en); end
        total++; if (slow_clk !== 1'b0)    begin bad++; $display("FAIL reset_slow_clk got=%0b want=0", slow_clk); end
        total++; if (cycle_count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", cycle_count); end
        total++; if (state !== 2'd0)       begin bad++; $display("FAIL reset_state got=%0d want=0", state); end
        total++; if (halted !== 1'b1)      begin bad++; $display("FAIL reset_halted got=%0b want=1", halted); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid_run();
        apply_reset();
        div_val = 4'd5;
        mode = 2'b01;
        for (int i = 0; i < 12; i++) tick();
        // state RUN after 1st edge, pulses at 5 and 10 cycles later -> 2
        total++; if (cycle_count !== 4'd2) begin bad++; $display("FAIL midrun_count_before got=%0d want=2", cycle_count); end
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (state !== 2'd0)       begin bad++; $display("FAIL midrun_state got=%0d want=0", state); end
        total++; if (cycle_count !== 4'd0) begin bad++; $display("FAIL midrun_count got=%0d want=0", cycle_count); end
        total++; if (cpu_en !== 1'b0)      begin bad++; $display("FAIL midrun_cpu_en got=%0b want=0", cpu_en); end
        total++; if (slow_clk !== 1'b0)    begin bad++; $display("FAIL midrun_slow got=%0b want=0", slow_clk); end
        total++; if (halted !== 1'b1)      begin bad++; $display("FAIL midrun_halted got=%0b want=1", halted); end
        mode = 2'b00;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_run_timing();
        apply_reset();
        div_val = 4'd5;
        mode = 2'b01;
        tick();
        total++; if (state !== 2'd1) begin bad++; $display("FAIL run_state got=%0d want=1", state); end
        for (int i = 1; i <= 50; i++) begin
            logic ep;
            tick();
            ep = (i % 5 == 0);
            if (ep) begin exp_count++; exp_slow = ~exp_slow; end
            total++; if (cpu_en !== ep)     begin bad++; $display("FAIL run_cpu_en i=%0d got=%0b want=%0b", i, cpu_en, ep); end
            total++; if (slow_clk !== exp_slow) begin bad++; $display("FAIL run_slow i=%0d got=%0b want=%0b", i, slow_clk, exp_slow); end
        end
        total++; if (cycle_count !== 4'd10) begin bad++; $display("FAIL run_count got=%0d want=10", cycle_count); end
        mode = 2'b00;
        tick();
        total++; if (state !== 2'd0) begin bad++; $display("FAIL run_halt_state got=%0d want=0", state); end
    endtask

    task automatic test_div_edges();
        apply_reset();
        div_val = 4'd0;
        mode = 2'b01;
        tick();
        for (int i = 1; i <= 8; i++) begin
            tick();
            total++; if (cpu_en !== 1'b1) begin bad++; $display("FAIL div0_cpu_en i=%0d got=%0b want=1", i, cpu_en); end
        end
        mode = 2'b00;
        tick();
        total++; if (cpu_en !== 1'b0) begin bad++; $display("FAIL div0_halt_cpu_en got=%0b want=0", cpu_en); end
        div_val = 4'd5;
        mode = 2'b01;
        tick();
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 3) div_val = 4'd3;
            total++; if (cpu_en !== (i % 5 == 0)) begin bad++; $display("FAIL divchg_old i=%0d got=%0b want=%0b", i, cpu_en, (i % 5 == 0)); end
        end
        mode = 2'b00;
        tick();
        mode = 2'b01;
        tick();
        for (int i = 1; i <= 12; i++) begin
            tick();
            total++; if (cpu_en !== (i % 3 == 0)) begin bad++; $display("FAIL divchg_new i=%0d got=%0b want=%0b", i, cpu_en, (i % 3 == 0)); end
        end
        mode = 2'b00;
        tick();
    endtask

    task automatic test_step();
        int n;
        int first;
        apply_reset();
        mode = 2'b10;
        tick();
        total++; if (state !== 2'd2) begin bad++; $display("FAIL step_state got=%0d want=2", state); end
        step_btn = 1'b1; tick(); tick(); step_btn = 1'b0;
        n = 0;
        for (int k = 0; k < 15; k++) begin tick(); if (cpu_en) n++; end
        total++; if (n != 0) begin bad++; $display("FAIL step_glitch pulses=%0d want=0", n); end
        step_btn = 1'b1;
        n = 0; first = -1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (cpu_en) begin n++; if (first < 0) first = k; end
        end
        step_btn = 1'b0;
        for (int k = 0; k < 15; k++) begin tick(); if (cpu_en) n++; end
        total++; if (n != 1) begin bad++; $display("FAIL step_clean pulses=%0d want=1", n); end
        total++; if (first < 6 || first > 8) begin bad++; $display("FAIL step_latency got=%0d want=6..8", first); end
        total++; if (cycle_count !== 4'd1) begin bad++; $display("FAIL step_count1 got=%0d want=1", cycle_count); end
        step_btn = 1'b1;
        n = 0;
        for (int k = 0; k < 40; k++) begin tick(); if (cpu_en) n++; end
        step_btn = 1'b0;
        for (int k = 0; k < 15; k++) begin tick(); if (cpu_en) n++; end
        total++; if (n != 1) begin bad++; $display("FAIL step_held pulses=%0d want=1", n); end
        total++; if (cycle_count !== 4'd2) begin bad++; $display("FAIL step_count2 got=%0d want=2", cycle_count); end
        total++; if (slow_clk !== 1'b0) begin bad++; $display("FAIL step_slow got=%0b want=0", slow_clk); end
        // a press accepted while halted must not be replayed on entering STEP
        mode = 2'b00;
        tick();
        step_btn = 1'b1;
        for (int k = 0; k < 20; k++) tick();
        step_btn = 1'b0;
        mode = 2'b10;
        n = 0;
        for (int k = 0; k < 20; k++) begin tick(); if (cpu_en) n++; end
        total++; if (n != 0 || cycle_count !== 4'd2) begin bad++; $display("FAIL step_discard pulses=%0d count=%0d want 0/2", n, cycle_count); end
        mode = 2'b00;
        tick();
    endtask

    task automatic test_breakpoint();
        int c;
        logic broke;
        apply_reset();
        div_val = 4'd2; bp_en = 1'b1; bp_cycle = 4'd7;
        mode = 2'b01;
        tick();
        c = 0; broke = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            logic ep;
            tick();
            ep = !broke && (i % 2 == 0);
            if (ep) begin c++; if (c == 7) broke = 1'b1; end
            total++; if (cpu_en !== ep) begin bad++; $display("FAIL bp_cpu_en i=%0d got=%0b want=%0b", i, cpu_en, ep); end
        end
        total++; if (cycle_count !== 4'd7) begin bad++; $display("FAIL bp_count got=%0d want=7", cycle_count); end
        total++; if (state !== 2'd3)       begin bad++; $display("FAIL bp_state got=%0d want=3", state); end
        total++; if (halted !== 1'b1)      begin bad++; $display("FAIL bp_halted got=%0b want=1", halted); end
        mode = 2'b10;
        for (int k = 0; k < 3; k++) tick();
        total++; if (state !== 2'd3) begin bad++; $display("FAIL bp_step_hold got=%0d want=3", state); end
        mode = 2'b00;
        tick();
        total++; if (state !== 2'd0) begin bad++; $display("FAIL bp_exit got=%0d want=0", state); end
        bp_en = 1'b0;
    endtask

    task automatic test_wrap();
        apply_reset();
        div_val = 4'd1; bp_en = 1'b0; bp_cycle = 4'd5;
        mode = 2'b01;
        tick();
        for (int k = 0; k < 15; k++) tick();
        total++; if (cycle_count !== 4'hF) begin bad++; $display("FAIL wrap_pre got=%0d want=15", cycle_count); end
        bp_en = 1'b1;
        tick();
        total++; if (cycle_count !== 4'd0 || state !== 2'd1) begin bad++; $display("FAIL wrap_nobp count=%0d state=%0d want 0/1", cycle_count, state); end
        mode = 2'b00;
        tick();
        apply_reset();
        bp_en = 1'b1; bp_cycle = 4'd0;
        mode = 2'b01;
        tick();
        for (int k = 0; k < 15; k++) tick();
        total++; if (state !== 2'd1) begin bad++; $display("FAIL wrap_bp0_early state=%0d want=1", state); end
        tick();
        total++; if (cycle_count !== 4'd0 || state !== 2'd3) begin bad++; $display("FAIL wrap_bp0 count=%0d state=%0d want 0/3", cycle_count, state); end
        mode = 2'b11;
        tick();
        total++; if (state !== 2'd0) begin bad++; $display("FAIL wrap_mode11 got=%0d want=0", state); end
        bp_en = 1'b0;
    endtask

    task automatic test_random();
        apply_reset();
        for (int it = 0; it < 20; it++) begin
            int lat;
            int len;
            logic broke;
            logic [1:0] hcode;
            div_val  = 4'($urandom_range(0, 15));
            lat      = (div_val == 4'd0) ? 1 : int'(div_val);
            len      = $urandom_range(4, 50);
            bp_en    = 1'($urandom_range(0, 1));
            bp_cycle = 4'($urandom_range(0, 15));
            hcode    = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
            mode = 2'b01;
            tick();
            total++; if (state !== 2'd1) begin bad++; $display("FAIL rnd_enter it=%0d got=%0d want=1", it, state); end
            broke = 1'b0;
            for (int i = 1; i <= len; i++) begin
                logic ep;
                tick();
                ep = !broke && (i % lat == 0);
                if (ep) begin
                    exp_count = exp_count + 4'd1;
                    exp_slow  = ~exp_slow;
                    if (bp_en && exp_count == bp_cycle) broke = 1'b1;
                end
                total++; if (cpu_en !== ep) begin bad++; $display("FAIL rnd_cpu_en it=%0d i=%0d got=%0b want=%0b", it, i, cpu_en, ep); end
            end
            total++; if (cycle_count !== exp_count) begin bad++; $display("FAIL rnd_count it=%0d got=%0d want=%0d", it, cycle_count, exp_count); end
            total++; if (slow_clk !== exp_slow) begin bad++; $display("FAIL rnd_slow it=%0d got=%0b want=%0b", it, slow_clk, exp_slow); end
            total++; if (state !== (broke ? 2'd3 : 2'd1)) begin bad++; $display("FAIL rnd_state it=%0d got=%0d want=%0d", it, state, broke ? 3 : 1); end
            mode = hcode;
            tick();
            total++; if (state !== 2'd0 || halted !== 1'b1) begin bad++; $display("FAIL rnd_halt it=%0d state=%0d halted=%0b", it, state, halted); end
        end
        bp_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_reset_mid_run();
        test_run_timing();
        test_div_edges();
        test_step();
        test_breakpoint();
        test_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
